// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: multi-cycle multiply/divide sequencer beside the EX-stage ALU.
// Runs one radix-2 shift-add multiply or restoring divide per accepted start.
// It returns a 32-bit result with a one-cycle done_o pulse.
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   flush_i         abort the current op; no done_o, result_o left untouched
//   start_i         new op request, sampled only while idle
//   op_i            000 MUL.W, 001 MULH.W, 010 MULH.WU, 011 reserved,
//                   100 DIV.W, 101 MOD.W, 110 DIV.WU, 111 MOD.WU
//   src1_i, src2_i  rj (multiplicand/dividend), rk (multiplier/divisor)
//   busy_o          an op is in flight
//   done_o          one-cycle pulse, result_o valid in that cycle
//   result_o        last result; holds until the next completed op
module ex_muldiv_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter bit          DIV0_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = 5;
  localparam logic [CW-1:0] LAST_IT = CW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  state_e          state_q;
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt_q;
  logic [W2-1:0]   acc_q;      // MUL: {hi, multiplier}; DIV: {rem, quo}
  logic [XLEN-1:0] opb_q;      // MUL: |multiplicand|; DIV: |divisor|
  logic [XLEN-1:0] src1_q;
  logic            neg_res_q;
  logic            neg_rem_q;
  logic            div0_q;
  logic [XLEN-1:0] result_q;

  // Operand conditioning at accept: signed ops are those with op_i[1] == 0
  logic            sgn_op;
  logic            s1_neg, s2_neg;
  logic [XLEN-1:0] abs1, abs2;

  always_comb begin
    sgn_op = ~op_i[1];
    s1_neg = sgn_op & src1_i[XLEN-1];
    s2_neg = sgn_op & src2_i[XLEN-1];
    abs1   = s1_neg ? (~src1_i + XLEN'(1)) : src1_i;
    abs2   = s2_neg ? (~src2_i + XLEN'(1)) : src2_i;
  end

  // One radix-2 step for each datapath
  logic [XLEN:0]   mul_sum;
  logic [W2-1:0]   mul_next;
  logic [W2:0]     div_sh;
  logic [XLEN:0]   rem_t;
  logic [XLEN-1:0] rem_sub;
  logic [W2-1:0]   div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_sh   = {acc_q, 1'b0};
    // Remainder after shift can need XLEN+1 bits when the divisor exceeds 2^31
    rem_t    = div_sh[W2:XLEN];
    rem_sub  = rem_t[XLEN-1:0] - opb_q;
    div_next = (rem_t >= {1'b0, opb_q}) ? {rem_sub, div_sh[XLEN-1:1], 1'b1}
                                        : div_sh[W2-1:0];
  end

  // Sign correction and result selection, used in FIN
  logic [W2-1:0]   prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fin_res;

  always_comb begin
    prod_fix = neg_res_q ? (~acc_q + W2'(1)) : acc_q;
    quo_fix  = neg_res_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[W2-1:XLEN] + XLEN'(1)) : acc_q[W2-1:XLEN];
    fin_res  = '0;
    case (op_q)
      3'b000:         fin_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010: fin_res = prod_fix[W2-1:XLEN];
      3'b100, 3'b110: fin_res = div0_q ? '1 : quo_fix;
      3'b101, 3'b111: fin_res = div0_q ? src1_q : rem_fix;
      default:        fin_res = '0;
    endcase
  end

  // A flush arriving in FIN must still suppress this cycle's done_o and result
  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_FIN) & ~flush_i;
  assign result_o = done_o ? fin_res : result_q;

  // Sequencer and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      opb_q     <= '0;
      src1_q    <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      result_q  <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q      <= op_i;
            src1_q    <= src1_i;
            div0_q    <= (src2_i == '0);
            neg_res_q <= s1_neg ^ s2_neg;
            neg_rem_q <= s1_neg;
            cnt_q     <= '0;
            if (op_i[2]) begin
              acc_q <= {{XLEN{1'b0}}, abs1};
              opb_q <= abs2;
            end else begin
              acc_q <= {{XLEN{1'b0}}, abs2};
              opb_q <= abs1;
            end
            if (op_i == 3'b011)                           state_q <= S_FIN;
            else if (op_i[2] && DIV0_FAST && src2_i == '0) state_q <= S_FIN;
            else if (op_i[2])                             state_q <= S_DIV;
            else                                          state_q <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q <= mul_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_IT) begin
            cnt_q   <= '0;
            state_q <= S_FIN;
          end
        end
        S_DIV: begin
          acc_q <= div_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST_IT) begin
            cnt_q   <= '0;
            state_q <= S_FIN;
          end
        end
        S_FIN: begin
          result_q <= fin_res;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: two instances (fast and full-length divide-by-zero)
// driven in parallel and checked against an arithmetic reference model.
module tb_ex_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, start;
  logic [2:0]  op;
  logic [31:0] s1, s2;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_ctrl #(.XLEN(32), .DIV0_FAST(1'b1)) dut0 (
    .clk(clk), .rst(rst), .flush_i(flush), .start_i(start), .op_i(op),
    .src1_i(s1), .src2_i(s2), .busy_o(busy0), .done_o(done0), .result_o(res0));

  ex_muldiv_ctrl #(.XLEN(32), .DIV0_FAST(1'b0)) dut1 (
    .clk(clk), .rst(rst), .flush_i(flush), .start_i(start), .op_i(op),
    .src1_i(s1), .src2_i(s2), .busy_o(busy1), .done_o(done1), .result_o(res1));

  // Reference result from plain 64-bit / integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    int         ia, ib;
    logic [63:0] p;
    ia = a; ib = b; sa = ia; sb = ib;
    case (o)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      3'd6: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd7: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] b, input bit fast);
    if (o == 3'd3) return 1;
    if (o[2] && b == 32'd0 && fast) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 20));
      1: return 32'd0 - 32'($urandom_range(1, 20));
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from an idle cycle; returns results/latencies for both DUTs
  // (latency 0 means no done_o within the budget). Leaves the bench in an idle cycle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r0, output logic [31:0] r1,
                        output int l0, output int l1);
    op = o; s1 = a; s2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s1 = $urandom; s2 = $urandom; op = 3'($urandom);
    l0 = 0; l1 = 0; r0 = '0; r1 = '0;
    for (int k = 1; k <= 40; k++) begin
      if (done0 && l0 == 0) begin l0 = k; r0 = res0; end
      if (done1 && l1 == 0) begin l1 = k; r1 = res1; end
      if (l0 != 0 && l1 != 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  // Run an op and compare both DUTs against the model
  task automatic check_op(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r0, r1, e;
    int l0, l1;
    run_op(o, a, b, r0, r1, l0, l1);
    e = ref_res(o, a, b);
    total++;
    if (r0 !== e) begin bad++; $display("FAIL %s_res op=%0d a=%h b=%h got=%h exp=%h", nm, o, a, b, r0, e); end
    total++;
    if (l0 !== ref_lat(o, b, 1'b1)) begin bad++; $display("FAIL %s_lat op=%0d b=%h got=%0d exp=%0d", nm, o, b, l0, ref_lat(o, b, 1'b1)); end
    total++;
    if (r1 !== e) begin bad++; $display("FAIL %s_res_slow op=%0d a=%h b=%h got=%h exp=%h", nm, o, a, b, r1, e); end
    total++;
    if (l1 !== ref_lat(o, b, 1'b0)) begin bad++; $display("FAIL %s_lat_slow op=%0d b=%h got=%0d exp=%0d", nm, o, b, l1, ref_lat(o, b, 1'b0)); end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; start = 1'b0; op = '0; s1 = '0; s2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy0, done0, res0} !== 34'd0) begin bad++; $display("FAIL reset got busy=%b done=%b res=%h exp 0", busy0, done0, res0); end
    total++;
    if ({busy1, done1, res1} !== 34'd0) begin bad++; $display("FAIL reset_slow got busy=%b done=%b res=%h exp 0", busy1, done1, res1); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    check_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL mul_busy_after got=%b exp=0", busy0); end
    check_op("mulh_w", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_op("mulh_wu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) check_op("mul_rand", 3'($urandom_range(0, 2)), pick_val(), pick_val());
  endtask

  task automatic test_div();
    check_op("div_w", 3'd4, 32'hFFFF_FFF9, 32'd2);
    check_op("mod_w", 3'd5, 32'hFFFF_FFF9, 32'd2);
    check_op("div_wu", 3'd6, 32'd100, 32'd7);
    check_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("mod_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF);
    check_op("divu_big", 3'd6, 32'hFFFF_FFF0, 32'h8000_0001);
    for (int i = 0; i < 10; i++) check_op("div_rand", 3'($urandom_range(4, 7)), pick_val(), pick_val());
  endtask

  task automatic test_div0_reserved();
    check_op("div0", 3'd4, 32'd5, 32'd0);
    check_op("mod0", 3'd5, 32'd5, 32'd0);
    check_op("divu0", 3'd6, 32'hDEAD_BEEF, 32'd0);
    check_op("modu0", 3'd7, 32'hDEAD_BEEF, 32'd0);
    check_op("reserved", 3'd3, $urandom, $urandom);
  endtask

  task automatic test_flush();
    bit seen;
    logic [31:0] prev;
    // flush at iteration 10 of a DIV, then a new op next cycle
    seen = 1'b0;
    op = 3'd4; s1 = 32'd1000; s2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      if (done0) seen = 1'b1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done0 || done1) seen = 1'b1;
      if (k == 0) begin
        total++;
        if (busy0 !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy0); end
      end
      @(posedge clk); #1;
    end
    total++;
    if (seen) begin bad++; $display("FAIL flush_nodone got done after flush exp none"); end
    check_op("after_flush", 3'd4, 32'hFFFF_FF00, 32'd9);
    // start and flush together: op dropped
    start = 1'b1; flush = 1'b1; op = 3'd0; s1 = 32'd3; s2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL start_flush_drop busy got=%b exp=0", busy0); end
    // flush in the done cycle suppresses done_o and the result update
    prev = res0;
    op = 3'd0; s1 = 32'd11; s2 = 32'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    total++;
    if (done0 !== 1'b1) begin bad++; $display("FAIL fin_done got=%b exp=1", done0); end
    flush = 1'b1;
    #1;
    total++;
    if (done0 !== 1'b0) begin bad++; $display("FAIL fin_flush_done got=%b exp=0", done0); end
    @(posedge clk); #1;
    flush = 1'b0;
    total++;
    if (busy0 !== 1'b0 || res0 !== prev) begin bad++; $display("FAIL fin_flush_hold busy=%b res=%h exp busy=0 res=%h", busy0, res0, prev); end
  endtask

  task automatic test_back_to_back();
    int dcyc[$];
    logic [31:0] a, b, e;
    bit busy_seen;
    a = $urandom; b = $urandom; e = ref_res(3'd0, a, b);
    busy_seen = 1'b0;
    op = 3'd0; s1 = a; s2 = b; start = 1'b1;
    for (int c = 1; c <= 103; c++) begin
      @(posedge clk); #1;
      if (done0) begin
        dcyc.push_back(c);
        total++;
        if (res0 !== e) begin bad++; $display("FAIL b2b_res cyc=%0d got=%h exp=%h", c, res0, e); end
      end
      if (c == 101) start = 1'b0;
    end
    total++;
    if (dcyc.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", dcyc.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (dcyc[i] != 33 + 34 * i) begin bad++; $display("FAIL b2b_cyc idx=%0d got=%0d exp=%0d", i, dcyc[i], 33 + 34 * i); end
      end
    end
    // rst at iteration 20: everything back to reset values
    op = 3'd1; s1 = 32'h1234_5678; s2 = 32'h9ABC_DEF0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin
      if (busy0) busy_seen = 1'b1;
      @(posedge clk); #1;
    end
    total++;
    if (!busy_seen || res0 === 32'd0) begin bad++; $display("FAIL pre_rst busy_seen=%b res=%h exp busy and nonzero res", busy_seen, res0); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if ({busy0, done0, res0} !== 34'd0) begin bad++; $display("FAIL mid_rst busy=%b done=%b res=%h exp 0", busy0, done0, res0); end
    check_op("after_rst", 3'd7, 32'd1000, 32'd33);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div0_reserved();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
